swc_rtu_rsp_buffer: RTL and testbench

SWC_RTU_RSP_BUFFER -- requirements
Module: swc_rtu_rsp_buffer

---
 rtl/swc_rtu_rsp_buffer.sv | 115 +++++++++++
 tb/tb_swc_rtu_rsp_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/swc_rtu_rsp_buffer.sv
// First-word-fall-through buffer between the RTU decision path and the switch core response port.
// Optional overflow statistics counter enabled by defining SWC_RTU_RSP_BUFFER_STATS_EN.
module swc_rtu_rsp_buffer #(
   parameter int g_num_ports  = 7,
   parameter int g_prio_width = 3,
   parameter int g_depth      = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        in_valid_i,
   input  logic [g_num_ports-1:0]      in_mask_i,
   input  logic                        in_drop_i,
   input  logic [g_prio_width-1:0]     in_prio_i,
   output logic                        in_full_o,
   output logic                        rsp_valid_o,
   input  logic                        rsp_ack_i,
   output logic [g_num_ports-1:0]      rsp_dst_port_mask_o,
   output logic                        rsp_drop_o,
   output logic [g_prio_width-1:0]     rsp_prio_o,
   output logic [$clog2(g_depth):0]    level_o,
   output logic                        overflow_o
`ifdef SWC_RTU_RSP_BUFFER_STATS_EN
   ,
   output logic [15:0]                 ovf_cnt_o
`endif
);

   localparam int PW = $clog2(g_depth);
   localparam int LW = PW + 1;

   typedef struct packed {
      logic [g_num_ports-1:0]  mask;
      logic                    drop;
      logic [g_prio_width-1:0] prio;
   } entry_t;

   entry_t          mem [g_depth];
   entry_t          in_entry;
   entry_t          head;
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]   level_q, level_next;
   logic            valid_q, full_q, ovf_q;
   logic            armed_q;
   logic            pop, wr_ok, wr_drop;

   // An all-zero mask forwards to nobody, so it is stored as an explicit drop.
   assign in_entry.mask = in_mask_i;
   assign in_entry.drop = in_drop_i | (in_mask_i == '0);
   assign in_entry.prio = in_prio_i;

   // NOTE: always_comb gives every output a default first so no latch can be inferred.
   always_comb begin
      pop        = 1'b0;
      wr_ok      = 1'b0;
      wr_drop    = 1'b0;
      level_next = level_q;
      if (armed_q) begin
         pop     = rsp_ack_i & valid_q;
         wr_ok   = in_valid_i & (~full_q | pop);
         wr_drop = in_valid_i & full_q & ~pop;
      end
      level_next = level_q + LW'(wr_ok) - LW'(pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         // The first edge after reset release only arms the buffer.
         armed_q <= 1'b1;
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
         level_q <= level_next;
         valid_q <= (level_next != '0);
         full_q  <= (level_next == LW'(g_depth));
         ovf_q   <= wr_drop;
      end
   end

   // NOTE: storage is deliberately not reset; occupancy is tracked by the pointers and level.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr_q] <= in_entry;
   end

   assign head                = mem[rd_ptr_q];
   assign rsp_valid_o         = valid_q;
   assign rsp_dst_port_mask_o = valid_q ? head.mask : '0;
   assign rsp_drop_o          = valid_q ? head.drop : 1'b0;
   assign rsp_prio_o          = valid_q ? head.prio : '0;
   assign in_full_o           = full_q;
   assign level_o             = level_q;
   assign overflow_o          = ovf_q;

`ifdef SWC_RTU_RSP_BUFFER_STATS_EN
   logic [15:0] ovf_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_cnt_q <= '0;
      end else if (wr_drop && ovf_cnt_q != 16'hFFFF) begin
         ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end
   end

   assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_swc_rtu_rsp_buffer.sv
// Directed and random scoreboard bench for swc_rtu_rsp_buffer (depth 4, 7 ports, 3-bit priority).
module tb_swc_rtu_rsp_buffer;

   localparam int NP    = 7;
   localparam int PRW   = 3;
   localparam int DEPTH = 4;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             in_valid_i;
   logic [NP-1:0]    in_mask_i;
   logic             in_drop_i;
   logic [PRW-1:0]   in_prio_i;
   logic             in_full_o;
   logic             rsp_valid_o;
   logic             rsp_ack_i;
   logic [NP-1:0]    rsp_dst_port_mask_o;
   logic             rsp_drop_o;
   logic [PRW-1:0]   rsp_prio_o;
   logic [2:0]       level_o;
   logic             overflow_o;
`ifdef SWC_RTU_RSP_BUFFER_STATS_EN
   logic [15:0]      ovf_cnt_o;
`endif

   typedef struct {
      logic [NP-1:0]  mask;
      logic           drop;
      logic [PRW-1:0] prio;
   } ent_t;

   ent_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   exp_ovf_cnt = 0;

   always #5 clk_i = ~clk_i;

   swc_rtu_rsp_buffer #(
      .g_num_ports (NP),
      .g_prio_width(PRW),
      .g_depth     (DEPTH)
   ) dut (
      .clk_i              (clk_i),
      .rst_n_i            (rst_n_i),
      .in_valid_i         (in_valid_i),
      .in_mask_i          (in_mask_i),
      .in_drop_i          (in_drop_i),
      .in_prio_i          (in_prio_i),
      .in_full_o          (in_full_o),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ack_i          (rsp_ack_i),
      .rsp_dst_port_mask_o(rsp_dst_port_mask_o),
      .rsp_drop_o         (rsp_drop_o),
      .rsp_prio_o         (rsp_prio_o),
      .level_o            (level_o),
      .overflow_o         (overflow_o)
`ifdef SWC_RTU_RSP_BUFFER_STATS_EN
      ,
      .ovf_cnt_o          (ovf_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus; the queue holds what the buffer must contain, in order.
   task automatic cycle(input bit wv, input logic [NP-1:0] m, input bit d,
                        input logic [PRW-1:0] p, input bit ack);
      bit   pop, acc;
      ent_t e;
      pop = ack && (sb.size() > 0);
      acc = wv && ((sb.size() < DEPTH) || pop);
      if (sb.size() > 0) begin
         check("head_mask", rsp_dst_port_mask_o, sb[0].mask);
         check("head_drop", rsp_drop_o, sb[0].drop);
         check("head_prio", rsp_prio_o, sb[0].prio);
      end
      in_valid_i = wv;
      in_mask_i  = m;
      in_drop_i  = d;
      in_prio_i  = p;
      rsp_ack_i  = ack;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      rsp_ack_i  = 1'b0;
      if (pop) void'(sb.pop_front());
      if (acc) begin
         e.mask = m;
         e.drop = d || (m == '0);
         e.prio = p;
         sb.push_back(e);
      end
      if (wv && !acc && exp_ovf_cnt < 16'hFFFF) exp_ovf_cnt++;
      check("level", level_o, sb.size());
      check("valid", rsp_valid_o, sb.size() != 0);
      check("full", in_full_o, sb.size() == DEPTH);
      check("overflow", overflow_o, wv && !acc);
`ifdef SWC_RTU_RSP_BUFFER_STATS_EN
      check("ovf_cnt", ovf_cnt_o, exp_ovf_cnt);
`endif
   endtask

   initial begin
      logic [NP-1:0]  rm;
      logic [PRW-1:0] rp;
      logic           rd, ra;

      rst_n_i    = 1'b0;
      in_valid_i = 1'b0;
      in_mask_i  = '0;
      in_drop_i  = 1'b0;
      in_prio_i  = '0;
      rsp_ack_i  = 1'b0;
      #1;
      check("rst_level", level_o, 0);
      check("rst_valid", rsp_valid_o, 0);
      check("rst_full", in_full_o, 0);
      check("rst_ovf", overflow_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Single write into empty buffer, then ack.
      cycle(1, 7'h05, 0, 3'd3, 0);
      check("single_valid", rsp_valid_o, 1);
      check("single_mask", rsp_dst_port_mask_o, 7'h05);
      check("single_prio", rsp_prio_o, 3'd3);
      check("single_drop", rsp_drop_o, 0);
      cycle(0, '0, 0, '0, 1);
      check("single_empty_level", level_o, 0);
      // Ack while empty is ignored.
      cycle(0, '0, 0, '0, 1);

      // Zero mask is stored as drop.
      cycle(1, 7'h00, 0, 3'd6, 0);
      check("zmask_drop", rsp_drop_o, 1);
      check("zmask_mask", rsp_dst_port_mask_o, 7'h00);
      cycle(0, '0, 0, '0, 1);

      // Five writes without acks: fourth fills, fifth overflows once.
      cycle(1, 7'h11, 0, 3'd1, 0);
      cycle(1, 7'h22, 1, 3'd2, 0);
      cycle(1, 7'h33, 0, 3'd4, 0);
      cycle(1, 7'h44, 0, 3'd5, 0);
      check("fill_full", in_full_o, 1);
      cycle(1, 7'h55, 0, 3'd7, 0);
      check("fill_ovf_pulse", overflow_o, 1);
      cycle(0, '0, 0, '0, 0);
      check("fill_ovf_clear", overflow_o, 0);

      // Full with simultaneous write and ack: level holds, new entry emerges fourth.
      cycle(1, 7'h66, 0, 3'd6, 1);
      check("fullwr_level", level_o, 4);
      repeat (DEPTH + 1) cycle(0, '0, 0, '0, 1);

      // Random acks across pointer wrap.
      for (int i = 0; i < 20; i++) begin
         rm = NP'($urandom);
         rp = PRW'($urandom);
         rd = 1'($urandom);
         ra = 1'($urandom_range(0, 1));
         cycle(1, rm, rd, rp, ra);
      end
      repeat (DEPTH + 1) cycle(0, '0, 0, '0, 1);
      check("rand_drained", level_o, 0);

      // Reset mid-operation at level 3.
      cycle(1, 7'h01, 0, 3'd1, 0);
      cycle(1, 7'h02, 0, 3'd2, 0);
      cycle(1, 7'h03, 0, 3'd3, 0);
      check("pre_rst_level", level_o, 3);
      #2;
      rst_n_i = 1'b0;
      #1;
      check("mid_rst_level", level_o, 0);
      check("mid_rst_valid", rsp_valid_o, 0);
      check("mid_rst_full", in_full_o, 0);
      check("mid_rst_mask", rsp_dst_port_mask_o, 0);
      check("mid_rst_drop", rsp_drop_o, 0);
      check("mid_rst_prio", rsp_prio_o, 0);
      sb.delete();
      exp_ovf_cnt = 0;
      in_valid_i = 1'b1;
      in_mask_i  = 7'h7F;
      rsp_ack_i  = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("in_rst_level", level_o, 0);
      rst_n_i = 1'b1;
      // First edge after release must ignore the write.
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      rsp_ack_i  = 1'b0;
      check("post_rel_level", level_o, 0);
      check("post_rel_valid", rsp_valid_o, 0);
      cycle(1, 7'h2A, 1, 3'd5, 0);
      check("post_rst_mask", rsp_dst_port_mask_o, 7'h2A);
      check("post_rst_prio", rsp_prio_o, 3'd5);
      cycle(0, '0, 0, '0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
